traffic_phase_controller: RTL and testbench

Parametrised multi-phase traffic light controller and successor to the fixed two-road controller. It sequences NUM_PHASES signal phases, each with its own programmable green and yellow time. It supports per-phase vehicle sensors with phase skipping and one-shot green extension, and a pedestrian walk interval at the end of each cycle. Timing tables, the 1 Hz tick divider, input synchronisers and the walk latch are all internal, so the block drops in as the top-level core.

---
 rtl/traffic_phase_controller.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// Multi-phase traffic light controller: per-phase programmable timing, sensor skip/extension, pedestrian walk.
// Define TRAFFIC_FLASH_EN to add the Flash input and the flashing-yellow FLASH state.
module traffic_phase_controller #(
    parameter int NUM_PHASES    = 4,
    parameter int TIME_W        = 4,
    parameter int TICKS_PER_SEC = 100000000,
    parameter int DEF_GREEN     = 6,
    parameter int DEF_YELLOW    = 2,
    parameter int DEF_WALK      = 3,
    parameter int DEF_EXT       = 3
) (
    input  logic                          clk,
    input  logic                          Reset_n,
    input  logic [NUM_PHASES-1:0]         Sensor,
    input  logic                          Walk_Request,
    input  logic                          Reprogram,
    input  logic [$clog2(NUM_PHASES)-1:0] Phase_Sel,
    input  logic [1:0]                    Param_Sel,
    input  logic [TIME_W-1:0]             Time_Value,
`ifdef TRAFFIC_FLASH_EN
    input  logic                          Flash,
`endif
    output logic [NUM_PHASES-1:0]         Green,
    output logic [NUM_PHASES-1:0]         Yellow,
    output logic                          Walk,
    output logic [$clog2(NUM_PHASES)-1:0] Phase,
    output logic                          expired,
    output logic                          oneHz_enable
);

    localparam int PW = $clog2(NUM_PHASES);
    localparam int DW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

`ifdef TRAFFIC_FLASH_EN
    typedef enum logic [2:0] {S_GREEN, S_EXTEND, S_YELLOW, S_ALL_RED, S_WALK, S_FLASH} state_t;
`else
    typedef enum logic [2:0] {S_GREEN, S_EXTEND, S_YELLOW, S_ALL_RED, S_WALK} state_t;
`endif

    function automatic logic [NUM_PHASES-1:0] onehot(input logic [PW-1:0] p);
        logic [NUM_PHASES-1:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] v);
        return (v == '0) ? TIME_W'(1) : v;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [NUM_PHASES-1:0] sensor_meta, sensor_sync;
    logic                  walk_req_meta, walk_req_sync;
    logic                  prog_meta, prog_sync, prog_prev;
    logic                  prog_rise;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sensor_meta   <= '0;
            sensor_sync   <= '0;
            walk_req_meta <= 1'b0;
            walk_req_sync <= 1'b0;
            prog_meta     <= 1'b0;
            prog_sync     <= 1'b0;
            prog_prev     <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value, forming a real 2-flop chain.
            sensor_meta   <= Sensor;
            sensor_sync   <= sensor_meta;
            walk_req_meta <= Walk_Request;
            walk_req_sync <= walk_req_meta;
            prog_meta     <= Reprogram;
            prog_sync     <= prog_meta;
            prog_prev     <= prog_sync;
        end
    end

    assign prog_rise = prog_sync & ~prog_prev;

    logic flash_sync;
`ifdef TRAFFIC_FLASH_EN
    logic flash_meta;
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_meta <= 1'b0;
            flash_sync <= 1'b0;
        end else begin
            flash_meta <= Flash;
            flash_sync <= flash_meta;
        end
    end
`else
    assign flash_sync = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Timing tables
    // ------------------------------------------------------------------
    logic [TIME_W-1:0] green_tab  [NUM_PHASES];
    logic [TIME_W-1:0] yellow_tab [NUM_PHASES];
    logic [TIME_W-1:0] walk_time, ext_time;
    logic              sel_ok, wr_en, wr_green, wr_yellow, wr_walk, wr_ext;

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch can be inferred.
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (Phase_Sel == PW'(i)) sel_ok = 1'b1;
        end
    end

    assign wr_en     = prog_rise & sel_ok;
    assign wr_green  = wr_en && (Param_Sel == 2'd0);
    assign wr_yellow = wr_en && (Param_Sel == 2'd1);
    assign wr_walk   = wr_en && (Param_Sel == 2'd2);
    assign wr_ext    = wr_en && (Param_Sel == 2'd3);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: the tables are plain flops, not a RAM macro, so they can reset straight to the defaults.
            for (int i = 0; i < NUM_PHASES; i++) begin
                green_tab[i]  <= TIME_W'(DEF_GREEN);
                yellow_tab[i] <= TIME_W'(DEF_YELLOW);
            end
            walk_time <= TIME_W'(DEF_WALK);
            ext_time  <= TIME_W'(DEF_EXT);
        end else begin
            if (wr_green)  green_tab[Phase_Sel]  <= Time_Value;
            if (wr_yellow) yellow_tab[Phase_Sel] <= Time_Value;
            if (wr_walk)   walk_time <= Time_Value;
            if (wr_ext)    ext_time  <= Time_Value;
        end
    end

    // ------------------------------------------------------------------
    // 1 Hz divider, restarted whenever the timer is reloaded
    // ------------------------------------------------------------------
    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic            tick, restart, flash_evt, advance;

    assign tick         = (div_cnt == DW'(TICKS_PER_SEC - 1));
    assign oneHz_enable = tick;

`ifdef TRAFFIC_FLASH_EN
    assign flash_evt = (state == S_FLASH) ? ~flash_sync : flash_sync;
`else
    assign flash_evt = flash_sync;
`endif
    assign advance = expired & ~flash_evt;
    assign restart = expired | flash_evt;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
        end else if (restart || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Next-phase selection and next-state decode
    // ------------------------------------------------------------------
    logic              fresh, walk_latch, walk_pend;
    logic [TIME_W-1:0] timer, load_raw;
    logic              sel_found;
    logic [PW-1:0]     sel_phase, nxt_phase;
    state_t            nxt_state;

    // Lowest eligible phase above the current one; iterate downward so the lowest wins.
    always_comb begin
        sel_found = 1'b0;
        sel_phase = '0;
        for (int i = NUM_PHASES - 1; i >= 1; i--) begin
            if (i > int'(Phase) && sensor_sync[i]) begin
                sel_found = 1'b1;
                sel_phase = PW'(i);
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_phase = Phase;
        case (state)
            S_GREEN:  nxt_state = sensor_sync[Phase] ? S_EXTEND : S_YELLOW;
            S_EXTEND: nxt_state = S_YELLOW;
            S_YELLOW: nxt_state = S_ALL_RED;
            S_ALL_RED: begin
                nxt_state = S_GREEN;
                if (fresh) begin
                    nxt_phase = '0;
                end else if (sel_found) begin
                    nxt_phase = sel_phase;
                end else begin
                    nxt_phase = '0;
                    if (walk_latch) nxt_state = S_WALK;
                end
            end
            S_WALK: begin
                nxt_state = S_GREEN;
                nxt_phase = '0;
            end
            default: ;
        endcase
    end

    // Interval for the state being entered, with same-cycle table writes forwarded.
    always_comb begin
        load_raw = TIME_W'(1);
        case (nxt_state)
            S_GREEN:  load_raw = (wr_green && Phase_Sel == nxt_phase) ? Time_Value : green_tab[nxt_phase];
            S_EXTEND: load_raw = wr_ext ? Time_Value : ext_time;
            S_YELLOW: load_raw = (wr_yellow && Phase_Sel == nxt_phase) ? Time_Value : yellow_tab[nxt_phase];
            S_WALK:   load_raw = wr_walk ? Time_Value : walk_time;
            default:  load_raw = TIME_W'(1);
        endcase
    end

    // ------------------------------------------------------------------
    // Phase FSM with timer and registered lamp outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_ALL_RED;
            Phase      <= '0;
            Green      <= '0;
            Yellow     <= '0;
            Walk       <= 1'b0;
            expired    <= 1'b0;
            timer      <= TIME_W'(1);
            fresh      <= 1'b1;
            walk_latch <= 1'b0;
            walk_pend  <= 1'b0;
        end else begin
            expired <= 1'b0;

            // A request seen during WALK is carried over so it earns the next cycle's walk.
            if (advance && state == S_WALK) begin
                walk_latch <= walk_pend | walk_req_sync;
                walk_pend  <= 1'b0;
            end else begin
                walk_latch <= walk_latch | walk_req_sync;
                if (state == S_WALK && walk_req_sync) walk_pend <= 1'b1;
            end

`ifdef TRAFFIC_FLASH_EN
            if (state == S_FLASH) begin
                if (!flash_sync) begin
                    state  <= S_ALL_RED;
                    Phase  <= '0;
                    Yellow <= '0;
                    timer  <= TIME_W'(1);
                    fresh  <= 1'b1;
                end else if (tick) begin
                    Yellow[0] <= ~Yellow[0];
                end
            end else if (flash_sync) begin
                state     <= S_FLASH;
                Green     <= '0;
                Yellow    <= NUM_PHASES'(1);
                Walk      <= 1'b0;
                walk_pend <= 1'b0;
            end else
`endif
            if (expired) begin
                state  <= nxt_state;
                Phase  <= nxt_phase;
                timer  <= at_least_one(load_raw);
                Green  <= (nxt_state == S_GREEN || nxt_state == S_EXTEND) ? onehot(nxt_phase) : '0;
                Yellow <= (nxt_state == S_YELLOW) ? onehot(nxt_phase) : '0;
                Walk   <= (nxt_state == S_WALK);
                if (state == S_ALL_RED) fresh <= 1'b0;
            end else if (tick && timer != '0) begin
                timer <= timer - TIME_W'(1);
                if (timer == TIME_W'(1)) expired <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed self-checking bench for traffic_phase_controller with a 4-cycle second.
// Measures each lamp interval in oneHz_enable ticks against hand-computed durations.
module tb_traffic_phase_controller;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] P0   = 4'b0001;
    localparam logic [3:0] P2   = 4'b0100;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [3:0] Sensor;
    logic       Walk_Request;
    logic       Reprogram;
    logic [1:0] Phase_Sel;
    logic [1:0] Param_Sel;
    logic [3:0] Time_Value;
`ifdef TRAFFIC_FLASH_EN
    logic       Flash;
`endif
    logic [3:0] Green;
    logic [3:0] Yellow;
    logic       Walk;
    logic [1:0] Phase;
    logic       expired;
    logic       oneHz_enable;

    int checks = 0;
    int errors = 0;

    traffic_phase_controller #(
        .NUM_PHASES    (4),
        .TIME_W        (4),
        .TICKS_PER_SEC (4),
        .DEF_GREEN     (6),
        .DEF_YELLOW    (2),
        .DEF_WALK      (3),
        .DEF_EXT       (3)
    ) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .Sensor       (Sensor),
        .Walk_Request (Walk_Request),
        .Reprogram    (Reprogram),
        .Phase_Sel    (Phase_Sel),
        .Param_Sel    (Param_Sel),
        .Time_Value   (Time_Value),
`ifdef TRAFFIC_FLASH_EN
        .Flash        (Flash),
`endif
        .Green        (Green),
        .Yellow       (Yellow),
        .Walk         (Walk),
        .Phase        (Phase),
        .expired      (expired),
        .oneHz_enable (oneHz_enable)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called on the first negedge of an interval: checks the lamps, then counts ticks until they change.
    task automatic seg(input string tag, input logic [3:0] g, input logic [3:0] y,
                       input logic w, input int exp_ticks);
        int ticks;
        int cyc;
        ticks = 0;
        cyc   = 0;
        check({tag, "_lamps"}, {23'd0, Green, Yellow, Walk}, {23'd0, g, y, w});
        while ({Green, Yellow, Walk} == {g, y, w} && cyc < 400) begin
            if (oneHz_enable) ticks++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ticks"}, ticks, exp_ticks);
    endtask

    task automatic pulse_walk();
        Walk_Request = 1'b1;
        repeat (2) @(negedge clk);
        Walk_Request = 1'b0;
    endtask

    task automatic program_entry(input logic [1:0] psel, input logic [1:0] fsel, input logic [3:0] val);
        Phase_Sel  = psel;
        Param_Sel  = fsel;
        Time_Value = val;
        Reprogram  = 1'b1;
        repeat (4) @(negedge clk);
        Reprogram  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        Reset_n      = 1'b0;
        Sensor       = '0;
        Walk_Request = 1'b0;
        Reprogram    = 1'b0;
        Phase_Sel    = '0;
        Param_Sel    = '0;
        Time_Value   = '0;
`ifdef TRAFFIC_FLASH_EN
        Flash        = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_lamps", {23'd0, Green, Yellow, Walk}, 32'd0);
        check("rst_phase", {30'd0, Phase}, 32'd0);
        check("rst_expired", {31'd0, expired}, 32'd0);
        check("rst_tick", {31'd0, oneHz_enable}, 32'd0);
        Reset_n = 1'b1;

        // Idle cycle: only phase 0 is ever served.
        seg("boot_ar", NONE, NONE, 1'b0, 1);
        check("boot_phase", {30'd0, Phase}, 32'd0);
        seg("idle_g0", P0, NONE, 1'b0, 6);
        seg("idle_y0", NONE, P0, 1'b0, 2);
        seg("idle_ar", NONE, NONE, 1'b0, 1);

        // Sensor on phase 2: skip phase 1, one extension, wrap back to 0.
        Sensor = 4'b0100;
        seg("sen_g0", P0, NONE, 1'b0, 6);
        seg("sen_y0", NONE, P0, 1'b0, 2);
        seg("sen_ar0", NONE, NONE, 1'b0, 1);
        check("sen_phase2", {30'd0, Phase}, 32'd2);
        seg("sen_g2", P2, NONE, 1'b0, 9);
        seg("sen_y2", NONE, P2, 1'b0, 2);
        Sensor = '0;
        seg("sen_ar2", NONE, NONE, 1'b0, 1);
        check("sen_back0", {30'd0, Phase}, 32'd0);

        // Walk request during green, serviced after the wrap.
        fork pulse_walk(); join_none
        seg("w1_g0", P0, NONE, 1'b0, 6);
        seg("w1_y0", NONE, P0, 1'b0, 2);
        seg("w1_ar", NONE, NONE, 1'b0, 1);
        seg("w1_walk", NONE, NONE, 1'b1, 3);
        check("w1_phase", {30'd0, Phase}, 32'd0);
        seg("w1_g0b", P0, NONE, 1'b0, 6);
        seg("w1_y0b", NONE, P0, 1'b0, 2);
        seg("w1_arb", NONE, NONE, 1'b0, 1);

        // Latch cleared: no walk this time; a request during WALK earns another.
        fork pulse_walk(); join_none
        seg("w2_g0", P0, NONE, 1'b0, 6);
        seg("w2_y0", NONE, P0, 1'b0, 2);
        seg("w2_ar", NONE, NONE, 1'b0, 1);
        fork pulse_walk(); join_none
        seg("w2_walk", NONE, NONE, 1'b1, 3);
        seg("w3_g0", P0, NONE, 1'b0, 6);
        seg("w3_y0", NONE, P0, 1'b0, 2);
        seg("w3_ar", NONE, NONE, 1'b0, 1);
        seg("w3_walk", NONE, NONE, 1'b1, 3);

        // Reprogram green[0]: running interval untouched, next visit uses the new value.
        fork program_entry(2'd0, 2'd0, 4'd9); join_none
        seg("rp_g0_old", P0, NONE, 1'b0, 6);
        seg("rp_y0", NONE, P0, 1'b0, 2);
        seg("rp_ar", NONE, NONE, 1'b0, 1);
        fork program_entry(2'd0, 2'd0, 4'd0); join_none
        seg("rp_g0_nine", P0, NONE, 1'b0, 9);
        seg("rp_y0b", NONE, P0, 1'b0, 2);
        seg("rp_arb", NONE, NONE, 1'b0, 1);
        seg("rp_g0_zero", P0, NONE, 1'b0, 1);

        // Reset in the middle of yellow.
        repeat (3) @(negedge clk);
        check("mid_yellow", {28'd0, Yellow}, {28'd0, P0});
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst2_lamps", {23'd0, Green, Yellow, Walk}, 32'd0);
        check("rst2_phase", {30'd0, Phase}, 32'd0);
        check("rst2_expired", {31'd0, expired}, 32'd0);
        @(negedge clk);
        Reset_n = 1'b1;
        seg("rst2_ar", NONE, NONE, 1'b0, 1);
        seg("rst2_g0_def", P0, NONE, 1'b0, 6);
        seg("rst2_y0", NONE, P0, 1'b0, 2);

`ifdef TRAFFIC_FLASH_EN
        begin
            int   cyc;
            logic prev;
            logic exp_y;
            Flash = 1'b1;
            cyc = 0;
            while (Yellow != P0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("fl_entry", {23'd0, Green, Yellow, Walk}, {23'd0, NONE, P0, 1'b0});
            for (int k = 0; k < 3; k++) begin
                prev  = Yellow[0];
                exp_y = ~prev;
                cyc   = 0;
                while (!oneHz_enable && cyc < 20) begin
                    @(negedge clk);
                    cyc++;
                end
                @(negedge clk);
                check("fl_toggle", {31'd0, Yellow[0]}, {31'd0, exp_y});
                check("fl_others", {24'd0, Green, Yellow[3:1], Walk}, 32'd0);
            end
            Flash = 1'b0;
            repeat (3) @(negedge clk);
            seg("fl_ar", NONE, NONE, 1'b0, 1);
            check("fl_phase", {30'd0, Phase}, 32'd0);
            seg("fl_g0", P0, NONE, 1'b0, 6);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
